// File: rtl/fft_pkg.sv
// Shared types for the fft_np frame controller: complex sample layout, FSM states
// and the bit-reverse helper used to restore natural bin order.
package fft_pkg;

  localparam int CPLX_W = 16;

  // Real part sits in the low half and imag in the high half, matching the fft_np lane layout.
  typedef struct packed {
    logic signed [CPLX_W/2-1:0] im;
    logic signed [CPLX_W/2-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_e;

  function automatic logic [7:0] bitrev(input logic [7:0] v, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_drain_buf.sv
// N-slot output buffer holding one fft_np result frame, plus the drain read mux.
// FFT_FRAME_CTRL_BITREV_EN selects bit-reversed read order.
module fft_drain_buf
  import fft_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 16,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          cap_en_i,
  input  logic          clr_i,
  input  logic [N*SW-1:0] frame_i,
  input  logic [IW-1:0] idx_i,
  output logic [SW-1:0] data_o
);

  logic [N-1:0][SW-1:0] buf_q;
  logic [IW-1:0]        rd_idx;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)       buf_q <= '0;
    else if (clr_i)    buf_q <= '0;
    else if (cap_en_i) buf_q <= frame_i;
  end

`ifdef FFT_FRAME_CTRL_BITREV_EN
  assign rd_idx = IW'(bitrev(8'(idx_i), IW));
`else
  assign rd_idx = idx_i;
`endif

  assign data_o = buf_q[rd_idx];

endmodule

// File: rtl/fft_frame_ctrl.sv
// Serial valid/ready wrapper around the parallel fft_np core: fill a frame, wait the
// core latency, drain bins. Optional FFT_FRAME_CTRL_BITREV_EN reorders drained bins.
module fft_frame_ctrl
  import fft_pkg::*;
#(
  parameter int N            = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int FFT_LATENCY  = 0
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [SAMPLE_WIDTH-1:0]   s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [SAMPLE_WIDTH-1:0]   m_data,
  output logic                      m_last,
  output logic [N*SAMPLE_WIDTH-1:0] fft_data_in,
  input  logic [N*SAMPLE_WIDTH-1:0] fft_data_out,
  output logic                      busy,
  output logic [15:0]               frames_done
);

  localparam int            IW   = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N-1);
  localparam logic [3:0]    LAT  = 4'(FFT_LATENCY);

  state_e                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [3:0]                wcnt_q, wcnt_d;
  logic [15:0]               frames_q, frames_d;
  logic [N*SAMPLE_WIDTH-1:0] fin_q;
  logic                      wr_en, cap_en;
  logic [SAMPLE_WIDTH-1:0]   buf_data;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= S_FILL;
      idx_q    <= '0;
      wcnt_q   <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wcnt_q   <= wcnt_d;
      frames_q <= frames_d;
    end
  end

  // Flush wins over any handshake in the same cycle, including a sample offered while s_ready=1.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wcnt_d   = wcnt_q;
    frames_d = frames_q;
    wr_en    = 1'b0;
    cap_en   = 1'b0;
    if (flush) begin
      state_d = S_FILL;
      idx_d   = '0;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_FILL: if (s_valid) begin
          wr_en = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            wcnt_d  = LAT;
            state_d = S_WAIT;
          end else idx_d = idx_q + 1'b1;
        end
        S_WAIT: if (wcnt_q == '0) begin
          cap_en  = 1'b1;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else wcnt_d = wcnt_q - 1'b1;
        S_DRAIN: if (m_ready) begin
          if (idx_q == LAST) begin
            idx_d    = '0;
            frames_d = frames_q + 1'b1;
            state_d  = S_FILL;
          end else idx_d = idx_q + 1'b1;
        end
        default: state_d = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)    fin_q <= '0;
    else if (wr_en) fin_q[idx_q*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= s_data;
  end

  fft_drain_buf #(.N(N), .SW(SAMPLE_WIDTH), .IW(IW)) u_buf (
    .clk      (clk),
    .arst_n   (arst_n),
    .cap_en_i (cap_en),
    .clr_i    (flush),
    .frame_i  (fft_data_out),
    .idx_i    (idx_q),
    .data_o   (buf_data)
  );

  assign s_ready     = (state_q == S_FILL);
  assign m_valid     = (state_q == S_DRAIN);
  assign m_last      = m_valid && (idx_q == LAST);
  assign m_data      = m_valid ? buf_data : '0;
  assign busy        = (state_q != S_FILL) || (idx_q != '0);
  assign frames_done = frames_q;
  assign fft_data_in = fin_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl (N=4, FFT_LATENCY=3) against a 3-stage integer DFT model.
module tb_fft_frame_ctrl;
  import fft_pkg::*;

  localparam int N = 4, SW = 16, LAT = 3;

  logic clk = 1'b0;
  logic arst_n, flush, s_valid, s_ready, m_valid, m_ready, m_last, busy;
  logic [SW-1:0]   s_data, m_data;
  logic [N*SW-1:0] fin, fout;
  logic [15:0]     frames_done;

  int checks = 0, failures = 0;
  int exp_frames = 0;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.N(N), .SAMPLE_WIDTH(SW), .FFT_LATENCY(LAT)) dut (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .fft_data_in(fin), .fft_data_out(fout),
    .busy(busy), .frames_done(frames_done)
  );

  function automatic logic [15:0] cs(input int re, input int im);
    cplx_t c;
    c.re = re[7:0];
    c.im = im[7:0];
    return c;
  endfunction

  // Integer unscaled 4-point DFT, twiddles are powers of -j.
  function automatic logic [63:0] dft(input logic [63:0] x);
    logic [63:0] y;
    int re, im, xr, xi;
    for (int k = 0; k < 4; k++) begin
      re = 0; im = 0;
      for (int n = 0; n < 4; n++) begin
        xr = int'($signed(x[n*16 +: 8]));
        xi = int'($signed(x[n*16+8 +: 8]));
        case ((k*n) % 4)
          0: begin re += xr; im += xi; end
          1: begin re += xi; im -= xr; end
          2: begin re -= xr; im -= xi; end
          default: begin re -= xi; im += xr; end
        endcase
      end
      y[k*16 +: 16] = cs(re, im);
    end
    return y;
  endfunction

  logic passthru = 1'b0;
  logic [N*SW-1:0] p1 = '0, p2 = '0, p3 = '0;
  always @(posedge clk) begin
    p1 <= passthru ? fin : dft(fin);
    p2 <= p1;
    p3 <= p2;
  end
  assign fout = p3;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Feeds one frame back-to-back, then measures handshake-to-first-m_valid distance.
  task automatic send(input logic [3:0][SW-1:0] din);
    int n;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_data  = din[i];
      chk("fill_s_ready", s_ready, 1'b1);
      tick();
    end
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      chk("wait_s_ready", s_ready, 1'b0);
      chk("wait_busy", busy, 1'b1);
      tick();
      n++;
    end
    chk("first_valid_latency", n + 1, LAT + 2);
  endtask

  task automatic drain(input logic [3:0][SW-1:0] dout, input int stall_bin, input int stall_cyc);
    for (int b = 0; b < 4; b++) begin
      if (b == stall_bin) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          chk("stall_valid", m_valid, 1'b1);
          chk("stall_data", m_data, dout[b]);
          chk("stall_last", m_last, b == 3);
          chk("stall_s_ready", s_ready, 1'b0);
          tick();
        end
      end
      m_ready = 1'b1;
      chk("bin_valid", m_valid, 1'b1);
      chk($sformatf("bin%0d_data", b), m_data, dout[b]);
      chk($sformatf("bin%0d_last", b), m_last, b == 3);
      tick();
    end
    m_ready = 1'b0;
    exp_frames++;
    chk("post_drain_s_ready", s_ready, 1'b1);
    chk("post_drain_m_valid", m_valid, 1'b0);
    chk("frames_done", frames_done, exp_frames);
  endtask

  typedef struct packed {
    logic [3:0][SW-1:0] din;
    logic [3:0][SW-1:0] dout;
    logic               pt;
  } vec_t;

  vec_t vecs[5];
  logic [3:0][SW-1:0] last_in;

  initial begin
    vecs[0].din  = {cs(4,0), cs(3,0), cs(2,0), cs(1,0)};
    vecs[0].dout = {cs(-2,-2), cs(-2,0), cs(-2,2), cs(10,0)};
    vecs[0].pt   = 1'b0;
    vecs[1].din  = {cs(0,0), cs(0,0), cs(0,0), cs(1,0)};
    vecs[1].dout = {cs(1,0), cs(1,0), cs(1,0), cs(1,0)};
    vecs[1].pt   = 1'b0;
    vecs[2].din  = {cs(0,0), cs(0,0), cs(0,0), cs(0,1)};
    vecs[2].dout = {cs(0,1), cs(0,1), cs(0,1), cs(0,1)};
    vecs[2].pt   = 1'b0;
    vecs[3].din  = {cs(1,1), cs(1,1), cs(1,1), cs(1,1)};
    vecs[3].dout = {cs(0,0), cs(0,0), cs(0,0), cs(4,4)};
    vecs[3].pt   = 1'b0;
    vecs[4].din  = {cs(8,-4), cs(-7,3), cs(6,2), cs(5,-1)};
`ifdef FFT_FRAME_CTRL_BITREV_EN
    vecs[4].dout = {cs(8,-4), cs(6,2), cs(-7,3), cs(5,-1)};
`else
    vecs[4].dout = {cs(8,-4), cs(-7,3), cs(6,2), cs(5,-1)};
`endif
    vecs[4].pt   = 1'b1;

    arst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #3;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_fft_data_in", fin, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frames_done", frames_done, '0);
    tick(); tick();
    arst_n = 1'b1;
    tick();

    // Async reset while bin 2 is presented: outputs collapse within the cycle.
    send(vecs[0].din);
    m_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      chk("pre_rst_bin", m_data, vecs[0].dout[b]);
      tick();
    end
    m_ready = 1'b0;
    chk("pre_rst_bin2", m_data, vecs[0].dout[2]);
    chk("pre_rst_frames", frames_done, '0);
    arst_n = 1'b0;
    #1;
    chk("arst_m_valid", m_valid, 1'b0);
    chk("arst_s_ready", s_ready, 1'b1);
    chk("arst_m_last", m_last, 1'b0);
    chk("arst_m_data", m_data, '0);
    chk("arst_fft_data_in", fin, '0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_frames_done", frames_done, '0);
    #2 arst_n = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      passthru = vecs[v].pt;
      send(vecs[v].din);
      drain(vecs[v].dout, -1, 0);
      last_in = vecs[v].din;
    end
    passthru = 1'b0;

    // Sink stalls 3 cycles on bin 1.
    send(vecs[0].din);
    drain(vecs[0].dout, 1, 3);
    last_in = vecs[0].din;

    // Flush after two samples; a third sample offered during flush must be dropped.
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = cs(9, 9);
      tick();
    end
    chk("pre_flush_busy", busy, 1'b1);
    flush = 1'b1; s_data = cs(-1, -1);
    tick();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_busy", busy, 1'b0);
    chk("flush_s_ready", s_ready, 1'b1);
    chk("flush_frames", frames_done, exp_frames);
    chk("flush_fin_kept", fin, {last_in[3], last_in[2], cs(9,9), cs(9,9)});
    send(vecs[0].din);
    drain(vecs[0].dout, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
